// File: rtl/afe_serial_ctrl_pkg.sv
// afe_serial_ctrl_pkg: shared FSM encodings, default timing and sizing helper for the AFE sequencer
package afe_serial_ctrl_pkg;
   typedef enum logic [2:0] {
      ST_RESET = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SETUP = 3'd2,
      ST_SHIFT = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5,
      ST_SYNC  = 3'd6
   } state_e;
   localparam int ADDR_W_DEF      = 12;
   localparam int DATA_W_DEF      = 28;
   localparam int CLK_DIV_DEF     = 4;
   localparam int SL_SETUP_DEF    = 2;
   localparam int SL_HOLD_DEF     = 2;
   localparam int SL_GAP_DEF      = 4;
   localparam int RST_CYCLES_DEF  = 256;
   localparam int SYNC_CYCLES_DEF = 4;
   function automatic int max2(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/afe_serial_ctrl_if.sv
// afe_serial_ctrl_if: write-request handshake and control/status strobes between register block and sequencer
interface afe_serial_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 28
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              sync_req;
   logic              soft_rst_req;
   logic              busy;
   logic              done;
   modport master (output req_valid, req_addr, req_data, sync_req, soft_rst_req,
                   input  req_ready, busy, done);
   modport slave  (input  req_valid, req_addr, req_data, sync_req, soft_rst_req,
                   output req_ready, busy, done);
endinterface

// File: rtl/afe_ser_shift.sv
// afe_ser_shift: LSB-first serialiser; each bit is CLK_DIV cycles of sck low then CLK_DIV cycles high
module afe_ser_shift #(
   parameter int N       = 40,
   parameter int CLK_DIV = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [N-1:0] din,
   input  logic         start,
   output logic         last,
   output logic         sck,
   output logic         sdata
);
   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(N + 1);
   logic [N-1:0]  sh_q, sh_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          act_q, act_d, sck_q, sck_d;
   logic          ph_end, bit_end;
   assign ph_end  = act_q && ph_q == PW'(CLK_DIV - 1);
   assign bit_end = ph_end && sck_q;
   assign last    = bit_end && bit_q == BW'(N - 1);
   assign sck     = sck_q;
   assign sdata   = sh_q[0];
   // data only moves at the end of a high phase, so sdata is stable across each rising sck
   always_comb begin
      act_d = start || (act_q && !last);
      ph_d  = (start || ph_end) ? '0 : act_q ? ph_q + 1'b1 : ph_q;
      sck_d = start ? 1'b0 : ph_end ? !sck_q : sck_q;
      bit_d = start ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
      sh_d  = load ? din : bit_end ? sh_q >> 1 : sh_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q  <= '0;
         ph_q  <= '0;
         bit_q <= '0;
         act_q <= 1'b0;
         sck_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         ph_q  <= ph_d;
         bit_q <= bit_d;
         act_q <= act_d;
         sck_q <= sck_d;
      end
   end
endmodule

// File: rtl/afe_serial_ctrl.sv
// afe_serial_ctrl: AD9990 AFE pin sequencer -- reset sequence, sync pulses and framed 3-wire register writes
module afe_serial_ctrl
   import afe_serial_ctrl_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CLK_DIV     = CLK_DIV_DEF,
   parameter int SL_SETUP    = SL_SETUP_DEF,
   parameter int SL_HOLD     = SL_HOLD_DEF,
   parameter int SL_GAP      = SL_GAP_DEF,
   parameter int RST_CYCLES  = RST_CYCLES_DEF,
   parameter int SYNC_CYCLES = SYNC_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   afe_serial_ctrl_if.slave bus,
   output logic             afe_rst,
   output logic             afe_sync,
   output logic             afe_sl,
   output logic             afe_sck,
   output logic             afe_sdata
);
   localparam int N  = ADDR_W + DATA_W;
   localparam int CW = $clog2(max2(max2(RST_CYCLES, SYNC_CYCLES),
                                   max2(SL_GAP, max2(SL_SETUP, SL_HOLD))) + 1);
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          rst_q, rst_d, sync_q, sync_d, sl_q, sl_d;
   logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
   logic          load, start, last;
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q || bus.sync_req;
      load    = 1'b0;
      start   = 1'b0;
      case (state_q)
         ST_RESET: state_d = cnt_q == CW'(RST_CYCLES) ? ST_IDLE : ST_RESET;
         ST_IDLE: begin
            if (bus.soft_rst_req) begin
               state_d = ST_RESET;
               pend_d  = 1'b0;
            end else if (bus.req_valid) begin
               state_d = ST_SETUP;
               load    = 1'b1;
            end else if (pend_d) begin
               state_d = ST_SYNC;
               pend_d  = 1'b0;
            end
         end
         ST_SETUP: begin
            start   = cnt_q == CW'(SL_SETUP - 1);
            state_d = start ? ST_SHIFT : ST_SETUP;
         end
         ST_SHIFT: state_d = last ? ST_HOLD : ST_SHIFT;
         ST_HOLD:  state_d = cnt_q == CW'(SL_HOLD - 1) ? ST_GAP : ST_HOLD;
         ST_GAP:   state_d = cnt_q == CW'(SL_GAP - 1) ? ST_IDLE : ST_GAP;
         ST_SYNC:  state_d = cnt_q == CW'(SYNC_CYCLES - 1) ? ST_IDLE : ST_SYNC;
         default:  state_d = ST_RESET;
      endcase
      cnt_d   = state_d != state_q ? '0 : cnt_q + 1'b1;
      // outputs are decoded from the next state so every pin comes straight from a flop
      rst_d   = !(state_d == ST_RESET && cnt_d < CW'(RST_CYCLES));
      sync_d  = state_d == ST_SYNC;
      sl_d    = !(state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      ready_d = state_d == ST_IDLE;
      busy_d  = state_d != ST_IDLE;
      done_d  = (state_d == ST_GAP && cnt_d == CW'(SL_GAP - 1)) ||
                (state_d == ST_SYNC && cnt_d == CW'(SYNC_CYCLES - 1));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         rst_q   <= 1'b0;
         sync_q  <= 1'b0;
         sl_q    <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         rst_q   <= rst_d;
         sync_q  <= sync_d;
         sl_q    <= sl_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   afe_ser_shift #(.N(N), .CLK_DIV(CLK_DIV)) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .din   ({bus.req_data, bus.req_addr}),
      .start (start),
      .last  (last),
      .sck   (afe_sck),
      .sdata (afe_sdata)
   );
   assign afe_rst       = rst_q;
   assign afe_sync      = sync_q;
   assign afe_sl        = sl_q;
   assign bus.req_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_afe_serial_ctrl.sv
// tb_afe_serial_ctrl: scoreboard bench; expected frames queued at request time, captured frames compared on frame end
module tb_afe_serial_ctrl;
   localparam int AW = 12;
   localparam int DW = 28;
   localparam int N  = AW + DW;
   typedef struct {
      logic [N-1:0] frame;
      int           nbits;
      int           len;
   } rec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic afe_rst, afe_sync, afe_sl, afe_sck, afe_sdata;
   int errors = 0;
   int checks = 0;
   logic [N-1:0] exp_q[$];
   rec_t got_q[$];
   rec_t cur;
   logic in_f = 1'b0;
   logic psck = 1'b0;
   afe_serial_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   afe_serial_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(2), .SL_SETUP(2), .SL_HOLD(2),
      .SL_GAP(4), .RST_CYCLES(16), .SYNC_CYCLES(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .afe_rst   (afe_rst),
      .afe_sync  (afe_sync),
      .afe_sl    (afe_sl),
      .afe_sck   (afe_sck),
      .afe_sdata (afe_sdata)
   );
   always #5 clk = ~clk;
   // frame monitor: samples sdata on each sck rise while sl is low, drops frames cut by rst_n
   always @(negedge clk) begin
      if (!rst_n) in_f = 1'b0;
      else if (!afe_sl) begin
         if (!in_f) begin
            in_f = 1'b1;
            cur.frame = '0;
            cur.nbits = 0;
            cur.len = 0;
         end
         cur.len++;
         if (afe_sck && !psck) begin
            if (cur.nbits < N) cur.frame[cur.nbits] = afe_sdata;
            cur.nbits++;
         end
      end else if (in_f) begin
         got_q.push_back(cur);
         in_f = 1'b0;
      end
      psck = afe_sck;
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      int n = 0;
      logic bad = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({afe_rst, afe_sync, afe_sl, afe_sck, afe_sdata, bus.req_ready, bus.busy, bus.done} !== 8'b00100010) begin
         errors++;
         $display("FAIL reset_values: got %b expected %b", {afe_rst, afe_sync, afe_sl, afe_sck, afe_sdata,
                  bus.req_ready, bus.busy, bus.done}, 8'b00100010);
      end
      rst_n = 1'b1;
      while (afe_rst === 1'b0 && n < 100) begin
         n++;
         if (afe_sl !== 1'b1 || afe_sck !== 1'b0 || bus.req_ready !== 1'b0) bad = 1'b1;
         step();
      end
      checks++;
      if (n != 16) begin errors++; $display("FAIL powerup_rst_len: got %0d cycles expected 16", n); end
      checks++;
      if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ready_with_rst_rise: got %b expected 0", bus.req_ready); end
      step();
      checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_rst: got ready=%b busy=%b expected 1 0", bus.req_ready, bus.busy);
      end
      checks++;
      if (bad || afe_sl !== 1'b1 || afe_sck !== 1'b0) begin
         errors++;
         $display("FAIL powerup_pins: got glitch=%b sl=%b sck=%b expected 0 1 0", bad, afe_sl, afe_sck);
      end
   endtask
   task automatic test_single_write();
      int n = 1;
      rec_t r;
      logic [N-1:0] e;
      for (int i = 0; i < 50 && !bus.req_ready; i++) step();
      bus.req_addr = 12'h0A5;
      bus.req_data = 28'h0123456;
      bus.req_valid = 1'b1;
      exp_q.push_back({28'h0123456, 12'h0A5});
      step();
      bus.req_valid = 1'b0;
      while (bus.done !== 1'b1 && n < 400) begin step(); n++; end
      checks++;
      if (n != 168) begin errors++; $display("FAIL single_latency: got %0d cycles expected 168", n); end
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL single_frame: got %0d frames expected %0d", got_q.size(), exp_q.size());
      end else begin
         r = got_q.pop_front();
         e = exp_q.pop_front();
         if (r.frame !== e || r.nbits != N) begin
            errors++;
            $display("FAIL single_frame: got %h/%0d bits expected %h/%0d bits", r.frame, r.nbits, e, N);
         end
         checks++;
         if (r.len != 164) begin errors++; $display("FAIL single_sl_len: got %0d expected 164", r.len); end
      end
   endtask
   task automatic test_back_to_back();
      int cyc = 0, dn = 0, d1 = -1, acc2 = -1, hi = 0, gap = 0, lo = 0, lo_max = 0;
      logic drop = 1'b0;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      rec_t r;
      logic [N-1:0] e;
      for (int i = 0; i < 50 && !bus.req_ready; i++) step();
      a = AW'($urandom);
      d = DW'($urandom);
      bus.req_addr = a;
      bus.req_data = d;
      bus.req_valid = 1'b1;
      exp_q.push_back({d, a});
      step();
      cyc = 1;
      a = AW'($urandom);
      d = DW'($urandom);
      bus.req_addr = a;
      bus.req_data = d;
      exp_q.push_back({d, a});
      while (dn < 2 && cyc < 1000) begin
         if (bus.done === 1'b1) begin dn++; if (dn == 1) d1 = cyc; end
         lo = bus.busy === 1'b0 ? lo + 1 : 0;
         lo_max = lo > lo_max ? lo : lo_max;
         if (afe_sl === 1'b1) hi++;
         else begin
            if (hi > 0 && gap == 0) gap = hi;
            hi = 0;
         end
         if (bus.req_ready === 1'b1 && bus.req_valid === 1'b1) begin acc2 = cyc; drop = 1'b1; end
         step();
         cyc++;
         if (drop) begin bus.req_valid = 1'b0; drop = 1'b0; end
      end
      checks++;
      if (dn != 2 || d1 != 168) begin errors++; $display("FAIL b2b_done: got %0d dones first at %0d expected 2 at 168", dn, d1); end
      checks++;
      if (acc2 != d1 + 1) begin errors++; $display("FAIL b2b_accept: got cycle %0d expected %0d", acc2, d1 + 1); end
      checks++;
      if (gap != 5) begin errors++; $display("FAIL b2b_sl_gap: got %0d expected 5", gap); end
      checks++;
      if (lo_max != 1) begin errors++; $display("FAIL b2b_busy_drop: got %0d expected 1", lo_max); end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_q.size() == 0 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_frame%0d: got %0d frames expected %0d", k, got_q.size(), exp_q.size());
         end else begin
            r = got_q.pop_front();
            e = exp_q.pop_front();
            if (r.frame !== e || r.nbits != N || r.len != 164) begin
               errors++;
               $display("FAIL b2b_frame%0d: got %h/%0d bits/len %0d expected %h/%0d bits/len 164", k, r.frame, r.nbits, r.len, e, N);
            end
         end
      end
   endtask
   task automatic test_sync_with_write();
      int cyc = 1, dn = 0, d1 = -1, d2 = -1, s_hi = 0, s_first = -1;
      rec_t r;
      logic [N-1:0] e;
      for (int i = 0; i < 50 && !bus.req_ready; i++) step();
      bus.req_addr = 12'h3C0;
      bus.req_data = 28'hFEDCBA9;
      bus.req_valid = 1'b1;
      bus.sync_req = 1'b1;
      exp_q.push_back({28'hFEDCBA9, 12'h3C0});
      step();
      bus.req_valid = 1'b0;
      bus.sync_req = 1'b0;
      while (dn < 2 && cyc < 600) begin
         if (afe_sync === 1'b1) begin s_hi++; if (s_first < 0) s_first = cyc; end
         if (bus.done === 1'b1) begin dn++; if (dn == 1) d1 = cyc; else d2 = cyc; end
         if (dn < 2) begin step(); cyc++; end
      end
      step();
      checks++;
      if (dn != 2 || d2 != d1 + 5) begin errors++; $display("FAIL sync_dones: got %0d dones at %0d,%0d expected 2 spaced 5", dn, d1, d2); end
      checks++;
      if (s_first != d1 + 2) begin errors++; $display("FAIL sync_start: got cycle %0d expected %0d", s_first, d1 + 2); end
      checks++;
      if (s_hi != 4 || afe_sync !== 1'b0) begin errors++; $display("FAIL sync_len: got %0d cycles (now %b) expected 4 (now 0)", s_hi, afe_sync); end
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL sync_frame: got %0d frames expected %0d", got_q.size(), exp_q.size());
      end else begin
         r = got_q.pop_front();
         e = exp_q.pop_front();
         if (r.frame !== e || r.nbits != N) begin
            errors++;
            $display("FAIL sync_frame: got %h/%0d bits expected %h/%0d bits", r.frame, r.nbits, e, N);
         end
      end
   endtask
   task automatic test_soft_reset();
      int n = 0;
      logic bad = 1'b0;
      rec_t r;
      logic [N-1:0] e;
      for (int i = 0; i < 50 && !bus.req_ready; i++) step();
      bus.req_addr = 12'h00F;
      bus.req_data = 28'h5A5A5A5;
      bus.req_valid = 1'b1;
      exp_q.push_back({28'h5A5A5A5, 12'h00F});
      step();
      bus.req_valid = 1'b0;
      repeat (5) step();
      bus.sync_req = 1'b1;
      step();
      bus.sync_req = 1'b0;
      for (int i = 0; i < 400 && bus.done !== 1'b1; i++) step();
      step();
      checks++;
      if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL soft_idle: got ready=%b expected 1", bus.req_ready); end
      bus.soft_rst_req = 1'b1;
      bus.req_valid = 1'b1;
      step();
      bus.soft_rst_req = 1'b0;
      while (afe_rst === 1'b0 && n < 100) begin
         n++;
         if (bus.req_ready !== 1'b0 || afe_sl !== 1'b1) bad = 1'b1;
         step();
      end
      bus.req_valid = 1'b0;
      checks++;
      if (n != 16) begin errors++; $display("FAIL soft_rst_len: got %0d cycles expected 16", n); end
      checks++;
      if (bad) begin errors++; $display("FAIL soft_req_ignored: got accept/frame during reset expected none"); end
      for (int i = 0; i < 20; i++) begin
         if (afe_sync !== 1'b0 || bus.done !== 1'b0 || afe_sl !== 1'b1) bad = 1'b1;
         step();
      end
      checks++;
      if (bad) begin errors++; $display("FAIL soft_pending_cleared: got sync/done/frame after reset expected none"); end
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL soft_frame: got %0d frames expected %0d", got_q.size(), exp_q.size());
      end else begin
         r = got_q.pop_front();
         e = exp_q.pop_front();
         if (r.frame !== e || r.nbits != N) begin
            errors++;
            $display("FAIL soft_frame: got %h/%0d bits expected %h/%0d bits", r.frame, r.nbits, e, N);
         end
      end
   endtask
   task automatic test_abort();
      int rises = 0, n = 0;
      logic prev;
      for (int i = 0; i < 50 && !bus.req_ready; i++) step();
      bus.req_addr = 12'hABC;
      bus.req_data = 28'h1234567;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      prev = afe_sck;
      while ((rises < 20 || afe_sck === 1'b1) && n < 400) begin
         step();
         n++;
         if (afe_sck === 1'b1 && prev === 1'b0) rises++;
         prev = afe_sck;
      end
      checks++;
      if (afe_sl !== 1'b0 || rises != 20) begin errors++; $display("FAIL abort_mid_frame: got sl=%b rises=%0d expected 0 20", afe_sl, rises); end
      rst_n = 1'b0;
      step();
      checks++;
      if ({afe_rst, afe_sync, afe_sl, afe_sck, afe_sdata, bus.req_ready, bus.busy, bus.done} !== 8'b00100010) begin
         errors++;
         $display("FAIL abort_values: got %b expected %b", {afe_rst, afe_sync, afe_sl, afe_sck, afe_sdata,
                  bus.req_ready, bus.busy, bus.done}, 8'b00100010);
      end
      step();
      rst_n = 1'b1;
      n = 0;
      while (afe_rst === 1'b0 && n < 100) begin n++; step(); end
      checks++;
      if (n != 16) begin errors++; $display("FAIL abort_rst_len: got %0d cycles expected 16", n); end
      step();
      checks++;
      if (bus.req_ready !== 1'b1 || got_q.size() != 0) begin
         errors++;
         $display("FAIL abort_recover: got ready=%b frames=%0d expected 1 0", bus.req_ready, got_q.size());
      end
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.sync_req = 1'b0;
      bus.soft_rst_req = 1'b0;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_sync_with_write();
      test_soft_reset();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
